// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared lane types: element width, operand queue ids, VRF read tag
package ara_pkg;

    localparam int unsigned ELEN = 64;
    typedef logic [ELEN-1:0] elen_t;

    typedef enum logic [3:0] {
        AluA, AluB, MulFPUA, MulFPUB, MulFPUC, MaskB, MaskM, StA, SlideAddrGenA
    } opqueue_e;

    localparam int unsigned NrOperandQueues = 9;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned QueueIdxWidth = idx_width(NrOperandQueues);
    typedef logic [QueueIdxWidth-1:0] queue_idx_t;

    typedef struct packed {
        logic       valid;
        queue_idx_t queue;
    } vrf_tag_t;

    // Out-of-range queue indices never match, so they are never flushed or counted.
    function automatic logic queue_in_mask(logic [NrOperandQueues-1:0] mask, queue_idx_t queue);
        logic hit;
        hit = 1'b0;
        for (int unsigned q = 0; q < NrOperandQueues; q++) begin
            if (mask[q] && queue == queue_idx_t'(q)) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/vrf_operand_router_tag_pipe.sv
// rtl/vrf_operand_router_tag_pipe.sv - per-bank tag delay line matching VRF read latency
module vrf_tag_pipe
    import ara_pkg::*;
#(
    parameter int unsigned VrfLatency = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req,
    input  logic [QueueIdxWidth-1:0]     queue,
    input  logic [NrOperandQueues-1:0]   flush,
    output logic                         ret_valid,
    output logic [QueueIdxWidth-1:0]     ret_queue
);

    vrf_tag_t stage_q [VrfLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < VrfLatency; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0].valid <= req && !queue_in_mask(flush, queue);
            stage_q[0].queue <= queue;
            for (int unsigned i = 1; i < VrfLatency; i++) begin
                stage_q[i].valid <= stage_q[i-1].valid && !queue_in_mask(flush, stage_q[i-1].queue);
                stage_q[i].queue <= stage_q[i-1].queue;
            end
        end
    end

    // A flush in the return cycle also kills the tag currently pairing with rdata.
    assign ret_valid = stage_q[VrfLatency-1].valid
                       && !queue_in_mask(flush, stage_q[VrfLatency-1].queue);
    assign ret_queue = stage_q[VrfLatency-1].queue;

endmodule

// File: rtl/vrf_operand_router.sv
// rtl/vrf_operand_router.sv - steers VRF bank read data to operand queues with in-flight tracking
module vrf_operand_router
    import ara_pkg::*;
#(
    parameter  int unsigned NrBanks       = 8,
    parameter  int unsigned VrfLatency    = 1,
    localparam int unsigned InflightWidth = idx_width(NrBanks * VrfLatency + 1)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NrBanks-1:0]                            bank_req_i,
    input  logic [NrBanks-1:0][QueueIdxWidth-1:0]         bank_req_queue_i,
    input  logic [NrBanks-1:0][ELEN-1:0]                  vrf_rdata_i,
    input  logic [NrOperandQueues-1:0]                    flush_i,
    output logic [NrOperandQueues-1:0][ELEN-1:0]          operand_o,
    output logic [NrOperandQueues-1:0]                    operand_valid_o,
    output logic [NrOperandQueues-1:0][InflightWidth-1:0] inflight_o,
    output logic                                          collision_o
);

    localparam int MaxInflight = int'(NrBanks * VrfLatency);

    logic [NrBanks-1:0]                            ret_valid;
    logic [NrBanks-1:0][QueueIdxWidth-1:0]         ret_queue;
    logic [NrOperandQueues-1:0]                    sel_valid;
    logic [NrOperandQueues-1:0][ELEN-1:0]          sel_data;
    logic [NrOperandQueues-1:0][InflightWidth-1:0] inflight_d;
    logic                                          collide;
    logic                                          cnt_err;

    for (genvar b = 0; b < NrBanks; b++) begin : gen_bank
        vrf_tag_pipe #(
            .VrfLatency (VrfLatency)
        ) u_tag_pipe (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .req       (bank_req_i[b]),
            .queue     (bank_req_queue_i[b]),
            .flush     (flush_i),
            .ret_valid (ret_valid[b]),
            .ret_queue (ret_queue[b])
        );
    end

    always_comb begin
        sel_valid  = '0;
        sel_data   = '0;
        inflight_d = inflight_o;
        collide    = 1'b0;
        cnt_err    = 1'b0;
        for (int unsigned q = 0; q < NrOperandQueues; q++) begin
            int inc_cnt;
            int dec_cnt;
            int next_cnt;
            inc_cnt = 0;
            dec_cnt = 0;
            // Ascending bank scan: the first hit wins, later hits are dropped but still retire.
            for (int unsigned b = 0; b < NrBanks; b++) begin
                if (bank_req_i[b] && !flush_i[q] && bank_req_queue_i[b] == QueueIdxWidth'(q)) begin
                    inc_cnt = inc_cnt + 1;
                end
                if (ret_valid[b] && ret_queue[b] == QueueIdxWidth'(q)) begin
                    dec_cnt = dec_cnt + 1;
                    if (sel_valid[q]) begin
                        collide = 1'b1;
                    end else begin
                        sel_valid[q] = 1'b1;
                        sel_data[q]  = vrf_rdata_i[b];
                    end
                end
            end
            next_cnt = int'(inflight_o[q]) + inc_cnt - dec_cnt;
            if (next_cnt < 0 || next_cnt > MaxInflight) cnt_err = 1'b1;
            inflight_d[q] = flush_i[q] ? '0 : InflightWidth'(next_cnt);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            operand_o       <= '0;
            operand_valid_o <= '0;
            inflight_o      <= '0;
            collision_o     <= 1'b0;
        end else begin
            operand_valid_o <= sel_valid;
            for (int unsigned q = 0; q < NrOperandQueues; q++) begin
                if (sel_valid[q]) operand_o[q] <= sel_data[q];
            end
            inflight_o  <= inflight_d;
            collision_o <= collision_o | collide;
        end
    end

    inflight_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni) !cnt_err);

endmodule

// File: tb/tb_vrf_operand_router.sv
// tb/tb_vrf_operand_router.sv - randomized bench with a read-tracking reference model
module tb_vrf_operand_router;
    import ara_pkg::*;

    localparam int NB  = 8;
    localparam int LAT = 2;
    localparam int NQ  = NrOperandQueues;
    localparam int IW  = idx_width(NB * LAT + 1);

    logic                            clk_i = 1'b0;
    logic                            rst_ni = 1'b0;
    logic [NB-1:0]                   bank_req_i;
    logic [NB-1:0][QueueIdxWidth-1:0] bank_req_queue_i;
    logic [NB-1:0][ELEN-1:0]         vrf_rdata_i;
    logic [NQ-1:0]                   flush_i;
    logic [NQ-1:0][ELEN-1:0]         operand_o;
    logic [NQ-1:0]                   operand_valid_o;
    logic [NQ-1:0][IW-1:0]           inflight_o;
    logic                            collision_o;

    vrf_operand_router #(
        .NrBanks    (NB),
        .VrfLatency (LAT)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .bank_req_i       (bank_req_i),
        .bank_req_queue_i (bank_req_queue_i),
        .vrf_rdata_i      (vrf_rdata_i),
        .flush_i          (flush_i),
        .operand_o        (operand_o),
        .operand_valid_o  (operand_valid_o),
        .inflight_o       (inflight_o),
        .collision_o      (collision_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int bank;
        int queue;
        int due;
    } rd_t;

    rd_t         flight[$];
    logic [63:0] exp_operand [NQ];
    logic        exp_valid   [NQ];
    logic        exp_coll;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        flight.delete();
        for (int q = 0; q < NQ; q++) begin
            exp_operand[q] = '0;
            exp_valid[q]   = 1'b0;
        end
        exp_coll = 1'b0;
    endtask

    // Reads live as records until their due cycle; the lowest bank wins a queue.
    task automatic model_step();
        rd_t keep[$];
        int  nret [NQ];
        int  best [NQ];
        for (int q = 0; q < NQ; q++) begin
            exp_valid[q] = 1'b0;
            nret[q] = 0;
            best[q] = NB;
        end
        foreach (flight[i]) begin
            if (flush_i[flight[i].queue]) continue;
            if (flight[i].due == cyc) begin
                nret[flight[i].queue]++;
                if (flight[i].bank < best[flight[i].queue]) best[flight[i].queue] = flight[i].bank;
            end else begin
                keep.push_back(flight[i]);
            end
        end
        for (int q = 0; q < NQ; q++) begin
            if (nret[q] > 0) begin
                exp_valid[q]   = 1'b1;
                exp_operand[q] = vrf_rdata_i[best[q]];
            end
            if (nret[q] > 1) exp_coll = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            if (bank_req_i[b] && !flush_i[bank_req_queue_i[b]]) begin
                rd_t r;
                r.bank  = b;
                r.queue = int'(bank_req_queue_i[b]);
                r.due   = cyc + LAT;
                keep.push_back(r);
            end
        end
        flight = keep;
    endtask

    task automatic compare_all();
        for (int q = 0; q < NQ; q++) begin
            int cnt;
            cnt = 0;
            foreach (flight[i]) if (flight[i].queue == q) cnt++;
            check($sformatf("valid[%0d] cyc %0d", q, cyc), 64'(operand_valid_o[q]), 64'(exp_valid[q]));
            check($sformatf("operand[%0d] cyc %0d", q, cyc), operand_o[q], exp_operand[q]);
            check($sformatf("inflight[%0d] cyc %0d", q, cyc), 64'(inflight_o[q]), 64'(cnt));
        end
        check($sformatf("collision cyc %0d", cyc), 64'(collision_o), 64'(exp_coll));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic idle();
        bank_req_i       = '0;
        bank_req_queue_i = '0;
        flush_i          = '0;
        for (int b = 0; b < NB; b++) vrf_rdata_i[b] = {$urandom, $urandom};
    endtask

    task automatic req(input int b, input int q);
        bank_req_i[b]       = 1'b1;
        bank_req_queue_i[b] = QueueIdxWidth'(q);
    endtask

    int valid_seen;

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        compare_all();
        rst_ni = 1'b1;

        // Basic latency: bank 3 -> AluA, data appears LAT cycles later.
        idle(); req(3, AluA); tick();
        for (int i = 1; i < LAT; i++) begin idle(); tick(); end
        idle(); vrf_rdata_i[3] = 64'hDEAD_BEEF; tick();
        check("basic_valid", 64'(operand_valid_o[AluA]), 64'd1);
        check("basic_data", operand_o[AluA], 64'hDEAD_BEEF);
        repeat (3) begin idle(); tick(); end

        // Parallel steering: 8 banks to 8 distinct queues.
        idle();
        for (int b = 0; b < NB; b++) req(b, (b + 1) % NQ);
        tick();
        repeat (LAT + 2) begin idle(); tick(); end

        // Flush of StA with reads at every depth plus a concurrent AluB read.
        idle(); req(0, StA); tick();
        idle(); req(1, StA); req(2, StA); tick();
        idle(); req(3, StA); req(4, AluB); flush_i[StA] = 1'b1; tick();
        check("flush_inflight", 64'(inflight_o[StA]), 64'd0);
        repeat (LAT + 2) begin idle(); tick(); end

        // Back-to-back stream on bank 1 to MaskB.
        valid_seen = 0;
        for (int i = 0; i < 16 + LAT + 2; i++) begin
            idle();
            if (i < 16) req(1, MaskB);
            tick();
            if (operand_valid_o[MaskB]) valid_seen++;
        end
        check("stream_count", 64'(valid_seen), 64'd16);

        // Collision: banks 2 and 5 both to MulFPUA.
        idle(); req(2, MulFPUA); req(5, MulFPUA); tick();
        for (int i = 1; i < LAT; i++) begin idle(); tick(); end
        idle(); tick();
        check("collision_set", 64'(collision_o), 64'd1);
        repeat (3) begin idle(); tick(); end

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            idle();
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 1) == 1) req(b, $urandom_range(0, NQ - 1));
            end
            if ($urandom_range(0, 7) == 0) flush_i[$urandom_range(0, NQ - 1)] = 1'b1;
            tick();
        end

        // Reset with four reads outstanding.
        idle();
        for (int b = 0; b < 4; b++) req(b, b);
        tick();
        idle();
        rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk_i);
        #1;
        compare_all();
        rst_ni = 1'b1;
        repeat (LAT + 3) begin idle(); tick(); end

        for (int i = 0; i < 100; i++) begin
            idle();
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 3) == 0) req(b, $urandom_range(0, NQ - 1));
            end
            tick();
        end
        repeat (LAT + 2) begin idle(); tick(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
